zigzag_normalizer_mc: RTL and testbench
=======================================

Name: zigzag_normalizer_mc

Overview:
Multi-component successor of the zigzag normalizer in the JPEG decode path, between the Huffman decoder and the inverse cosine transform. It expands (run, coefficient) symbols into 64 coefficients per 8x8 block, in zigzag order, each tagged with its row and column. Compared with the single-channel version it adds parametrised coefficient width and channel count, per-channel DC prediction, ZRL handling, restart-marker predictor clearing, and overrun detection.

Parameters:
VERI_BIT, 12, signed coefficient width (in and out)
RUN_BIT, 4, zero-run field width
KANAL_SAYISI, 3, number of colour components
KANAL_BIT, 2, channel index width; must satisfy 2^KANAL_BIT >= KANAL_SAYISI

Ports:
clk_i  in  1  single clock, rising edge
rstn_i  in  1  asynchronous active-low reset
hd_run_i  in  RUN_BIT  zero run preceding the coefficient
hd_veri_i  in  VERI_BIT  signed coefficient; at block index 0 this is the DC difference
hd_kanal_i  in  KANAL_BIT  channel; sampled only on a DC symbol
hd_gecerli_i  in  1  symbol valid
hd_hazir_o  out  1  symbol ready
yeniden_i  in  1  restart pulse; clears all DC predictors
ct_veri_o  out  VERI_BIT  coefficient out
ct_row_o  out  3  row of the coefficient
ct_col_o  out  3  column of the coefficient
ct_kanal_o  out  KANAL_BIT  channel of the current block
ct_gecerli_o  out  1  output valid
ct_blok_son_o  out  1  high with the coefficient at index 63
ct_hazir_i  in  1  downstream ready
hata_o  out  1  sticky overrun error

Behaviour:
- Reset (asynchronous, rstn_i low):
  - All outputs 0; hd_hazir_o held 0 while rstn_i is low.
  - State BEKLE, index k = 0, all predictors 0, hata_o = 0.
  - Reset mid-block discards the partial block.
- Handshakes:
  - Symbol transfer: hd_gecerli_i && hd_hazir_o.
  - Output transfer: ct_gecerli_o && ct_hazir_i.
  - Outputs are registered. While ct_gecerli_o=1 and ct_hazir_i=0, every ct_* output stays frozen.
- hd_hazir_o = (state == BEKLE) && (!ct_gecerli_o || ct_hazir_i). This allows one run=0 symbol per cycle.
- Position: k maps to (row, col) through the standard JPEG zigzag table, e.g. k1=(0,1), k2=(1,0), k3=(2,0), k4=(1,1), k49=(7,3), k63=(7,7).
- States:
  - BEKLE: waits for a symbol.
    - k==0: DC symbol; run is ignored. pred[ch] <= pred[ch] + diff, mod 2^VERI_BIT. The new pred is emitted at k0 and ch is latched into ct_kanal_o.
    - k>0, run=0, veri=0 (EOB) -> DOLDUR.
    - k>0, run=15, veri=0 (ZRL) -> SIFIR with 16 zeros to emit.
    - Otherwise -> SIFIR with `run` zeros to emit, then DEGER (or DEGER directly if run=0).
  - SIFIR: emits one zero per output transfer. After the last zero -> DEGER, or BEKLE for ZRL.
  - DEGER: emits the coefficient, then -> BEKLE.
  - DOLDUR: emits zeros up to and including k=63, then -> BEKLE.
- Latency: a symbol accepted at edge N produces its first output valid after edge N.
- k increments on each output transfer. ct_blok_son_o=1 exactly when k=63. After k=63 transfers, k wraps to 0 and the next symbol is DC.
- Overrun: if a run or ZRL would place data beyond k=63:
  - Zeros are emitted through k=63 and the coefficient is dropped.
  - hata_o is set to 1 and stays set until reset.
  - The block ends normally.
- EOB at k=63 is impossible: k=63 always closes the block.
- yeniden_i (one cycle) clears all predictors. If it coincides with a DC accept, that DC uses pred=0, so the output equals the diff. A mid-block yeniden_i does not alter the block in progress.
- Predictors are independent per channel. A channel index >= KANAL_SAYISI sets hata_o and uses predictor 0.

Test Plan:
- Reset, then ch0 DC 5 followed by EOB -> 64 outputs: (0,0)=5 and 63 zeros; ct_blok_son_o only on (7,7); kanal=0.
- Next block ch0 DC -3 -> k0=2. Next block ch1 DC 7 -> k0=7 (independent predictor). yeniden_i pulse, then ch0 DC 4 -> k0=4.
- DC 1, (3,2), (1,3), EOB -> k0=1, k1..3=0, k4=(1,1)=2, k5=0, k6=(0,3)=3, rest 0.
- DC 0, ZRL x3, (0,9), EOB -> k1..48 zero, k49=(7,3)=9, k50..63 zero; hata_o=0.
- DC 0, ZRL x3, (15,4) -> zeros k49..63, value dropped, hata_o=1. The next symbol is treated as DC of a new block.
- ct_hazir_i low for 5 cycles mid-run -> outputs stable, hd_hazir_o=0, no coefficient lost or duplicated. Reset asserted at k=20 -> all outputs 0, and the next symbol is DC with pred=0.

Source files
------------

// File: rtl/zigzag_normalizer_mc.sv
// zigzag_normalizer_mc: turns Huffman (run, coefficient) symbols into 64 zigzag-ordered
// coefficients per 8x8 block. Each coefficient is tagged with its row, column and channel.
// The block also handles per-channel DC prediction, ZRL, restart clearing and overrun.
module zigzag_normalizer_mc #(
    parameter int VERI_BIT     = 12,
    parameter int RUN_BIT      = 4,
    parameter int KANAL_SAYISI = 3,
    parameter int KANAL_BIT    = 2
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [RUN_BIT-1:0]   hd_run_i,
    input  logic [VERI_BIT-1:0]  hd_veri_i,
    input  logic [KANAL_BIT-1:0] hd_kanal_i,
    input  logic                 hd_gecerli_i,
    output logic                 hd_hazir_o,
    input  logic                 yeniden_i,
    output logic [VERI_BIT-1:0]  ct_veri_o,
    output logic [2:0]           ct_row_o,
    output logic [2:0]           ct_col_o,
    output logic [KANAL_BIT-1:0] ct_kanal_o,
    output logic                 ct_gecerli_o,
    output logic                 ct_blok_son_o,
    input  logic                 ct_hazir_i,
    output logic                 hata_o
);
    typedef enum logic [1:0] {BEKLE, SIFIR, DEGER, DOLDUR} state_t;

    // Zigzag index -> raster position {row, col}
    localparam logic [5:0] ZZ_TABLE [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };
    localparam logic [KANAL_BIT-1:0] KANAL_MAX = KANAL_BIT'(KANAL_SAYISI - 1);
    localparam logic [RUN_BIT-1:0]   RUN_ZRL   = '1;
    localparam logic [RUN_BIT-1:0]   RUN_ONE   = RUN_BIT'(1);
    localparam logic [RUN_BIT:0]     CNT_ONE   = (RUN_BIT+1)'(1);

    state_t               r_state;
    logic [5:0]           r_k;
    logic [RUN_BIT:0]     r_zeros;
    logic                 r_zrl;
    logic [VERI_BIT-1:0]  r_val;
    logic [VERI_BIT-1:0]  r_pred [KANAL_SAYISI];
    logic [VERI_BIT-1:0]  r_ct_veri;
    logic [2:0]           r_ct_row;
    logic [2:0]           r_ct_col;
    logic [KANAL_BIT-1:0] r_ct_kanal;
    logic                 r_ct_gecerli;
    logic                 r_ct_blok_son;
    logic                 r_hata;

    logic                 w_out_free;
    logic                 w_hazir;
    logic                 w_emit;
    logic                 w_dc;
    logic                 w_kanal_ok;
    logic [KANAL_BIT-1:0] w_kanal_sel;
    logic [VERI_BIT-1:0]  w_dc_base;
    logic [VERI_BIT-1:0]  w_dc_new;
    logic [5:0]           w_zz;
    logic                 w_last;
    logic                 w_is_zrl;

    assign w_out_free  = !r_ct_gecerli || ct_hazir_i;
    assign w_hazir     = rstn_i && (r_state == BEKLE) && w_out_free;
    assign w_emit      = w_out_free && ((r_state != BEKLE) || hd_gecerli_i);
    assign w_dc        = hd_gecerli_i && w_hazir && (r_k == 6'd0);
    assign w_kanal_ok  = (hd_kanal_i <= KANAL_MAX);
    assign w_kanal_sel = w_kanal_ok ? hd_kanal_i : '0;
    assign w_dc_base   = yeniden_i ? '0 : r_pred[w_kanal_sel];
    assign w_dc_new    = w_dc_base + hd_veri_i;
    assign w_zz        = ZZ_TABLE[r_k];
    assign w_last      = (r_k == 6'd63);
    assign w_is_zrl    = (hd_run_i == RUN_ZRL) && (hd_veri_i == '0);

    // DC predictors: a restart clears them all, and a DC symbol updates its channel's predictor
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < KANAL_SAYISI; c++) r_pred[c] <= '0;
        end else begin
            if (yeniden_i) begin
                for (int c = 0; c < KANAL_SAYISI; c++) r_pred[c] <= '0;
            end
            if (w_dc) r_pred[w_kanal_sel] <= w_dc_new;
        end
    end

    // Expansion FSM: loads one coefficient into the output register whenever it is free
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state       <= BEKLE;
            r_k           <= '0;
            r_zeros       <= '0;
            r_zrl         <= 1'b0;
            r_val         <= '0;
            r_ct_veri     <= '0;
            r_ct_row      <= '0;
            r_ct_col      <= '0;
            r_ct_kanal    <= '0;
            r_ct_gecerli  <= 1'b0;
            r_ct_blok_son <= 1'b0;
            r_hata        <= 1'b0;
        end else if (w_emit) begin
            r_ct_gecerli  <= 1'b1;
            r_ct_row      <= w_zz[5:3];
            r_ct_col      <= w_zz[2:0];
            r_ct_blok_son <= w_last;
            r_k           <= r_k + 6'd1;
            unique case (r_state)
                BEKLE: begin
                    if (r_k == 6'd0) begin
                        r_ct_veri  <= w_dc_new;
                        r_ct_kanal <= hd_kanal_i;
                        if (!w_kanal_ok) r_hata <= 1'b1;
                    end else if (hd_run_i == '0) begin
                        r_ct_veri <= hd_veri_i;
                        if ((hd_veri_i == '0) && !w_last) r_state <= DOLDUR;
                    end else begin
                        r_ct_veri <= '0;
                        if (w_last) begin
                            r_hata <= 1'b1;
                        end else begin
                            r_zrl   <= w_is_zrl;
                            r_val   <= hd_veri_i;
                            r_zeros <= w_is_zrl ? {1'b0, hd_run_i} : ({1'b0, hd_run_i} - CNT_ONE);
                            r_state <= (w_is_zrl || (hd_run_i != RUN_ONE)) ? SIFIR : DEGER;
                        end
                    end
                end
                SIFIR: begin
                    r_ct_veri <= '0;
                    r_zeros   <= r_zeros - CNT_ONE;
                    if (w_last) begin
                        r_state <= BEKLE;
                        if ((r_zeros != CNT_ONE) || !r_zrl) r_hata <= 1'b1;
                    end else if (r_zeros == CNT_ONE) begin
                        r_state <= r_zrl ? BEKLE : DEGER;
                    end
                end
                DEGER: begin
                    r_ct_veri <= r_val;
                    r_state   <= BEKLE;
                end
                DOLDUR: begin
                    r_ct_veri <= '0;
                    if (w_last) r_state <= BEKLE;
                end
            endcase
        end else if (ct_hazir_i) begin
            r_ct_gecerli <= 1'b0;
        end
    end

    assign hd_hazir_o    = w_hazir;
    assign ct_veri_o     = r_ct_veri;
    assign ct_row_o      = r_ct_row;
    assign ct_col_o      = r_ct_col;
    assign ct_kanal_o    = r_ct_kanal;
    assign ct_gecerli_o  = r_ct_gecerli;
    assign ct_blok_son_o = r_ct_blok_son;
    assign hata_o        = r_hata;
endmodule

// File: tb/tb_zigzag_normalizer_mc.sv
// tb_zigzag_normalizer_mc: directed symbol streams with a behavioural model filling an
// expectation queue, and a monitor that pops and compares every output transfer.
module tb_zigzag_normalizer_mc;
    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b1;
    logic [3:0]  hd_run_i = '0;
    logic [11:0] hd_veri_i = '0;
    logic [1:0]  hd_kanal_i = '0;
    logic        hd_gecerli_i = 1'b0;
    logic        hd_hazir_o;
    logic        yeniden_i = 1'b0;
    logic [11:0] ct_veri_o;
    logic [2:0]  ct_row_o;
    logic [2:0]  ct_col_o;
    logic [1:0]  ct_kanal_o;
    logic        ct_gecerli_o;
    logic        ct_blok_son_o;
    logic        ct_hazir_i = 1'b1;
    logic        hata_o;

    typedef struct packed {
        logic [11:0] veri;
        logic [2:0]  row;
        logic [2:0]  col;
        logic [1:0]  kanal;
        logic        son;
    } expT;

    expT         expQ[$];
    int          testsRun = 0;
    int          testsFailed = 0;
    int          zzRow[64];
    int          zzCol[64];
    logic [11:0] mPred[3];
    int          mK;
    logic [1:0]  mKanal;
    logic        mHata;

    zigzag_normalizer_mc #(
        .VERI_BIT(12), .RUN_BIT(4), .KANAL_SAYISI(3), .KANAL_BIT(2)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .hd_run_i(hd_run_i), .hd_veri_i(hd_veri_i), .hd_kanal_i(hd_kanal_i),
        .hd_gecerli_i(hd_gecerli_i), .hd_hazir_o(hd_hazir_o), .yeniden_i(yeniden_i),
        .ct_veri_o(ct_veri_o), .ct_row_o(ct_row_o), .ct_col_o(ct_col_o),
        .ct_kanal_o(ct_kanal_o), .ct_gecerli_o(ct_gecerli_o),
        .ct_blok_son_o(ct_blok_son_o), .ct_hazir_i(ct_hazir_i), .hata_o(hata_o)
    );

    // 10 ns clock
    always #5 clk_i = ~clk_i;

    // One comparison: counts it, and reports a FAIL line when the values differ
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Builds the zigzag walk over the anti-diagonals: odd diagonals go down, even ones go up
    function automatic void buildZigzag();
        int idx = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 1) begin
                for (int r = lo; r <= hi; r++) begin zzRow[idx] = r; zzCol[idx] = s - r; idx++; end
            end else begin
                for (int r = hi; r >= lo; r--) begin zzRow[idx] = r; zzCol[idx] = s - r; idx++; end
            end
        end
    endfunction

    // Model reset: everything back to the start of a block with zero predictors
    function automatic void modelReset();
        for (int c = 0; c < 3; c++) mPred[c] = '0;
        mK = 0;
        mKanal = '0;
        mHata = 1'b0;
    endfunction

    // Queues one expected coefficient at the model's current index and advances it
    function automatic void pushExp(input logic [11:0] v);
        expT e;
        e.veri  = v;
        e.row   = 3'(zzRow[mK]);
        e.col   = 3'(zzCol[mK]);
        e.kanal = mKanal;
        e.son   = (mK == 63);
        expQ.push_back(e);
        mK = (mK + 1) % 64;
    endfunction

    // Behavioural expansion of one symbol into the expected coefficient stream
    task automatic modelSymbol(input logic [3:0] run, input logic [11:0] veri, input logic [1:0] ch, input logic restart);
        int  nz;
        int  sel;
        bit  zrl;
        if (restart) for (int c = 0; c < 3; c++) mPred[c] = '0;
        if (mK == 0) begin
            sel = (ch < 2'd3) ? int'(ch) : 0;
            if (ch >= 2'd3) mHata = 1'b1;
            mPred[sel] = mPred[sel] + veri;
            mKanal = ch;
            pushExp(mPred[sel]);
            return;
        end
        if (run == 4'd0 && veri == 12'd0) begin
            while (mK != 0) pushExp(12'd0);
            return;
        end
        zrl = (run == 4'd15 && veri == 12'd0);
        nz = zrl ? 16 : int'(run);
        for (int i = 0; i < nz; i++) begin
            pushExp(12'd0);
            if (mK == 0) begin
                if (i < nz - 1 || !zrl) mHata = 1'b1;
                return;
            end
        end
        if (!zrl) pushExp(veri);
    endtask

    // Offers one symbol, updates the model, and waits (bounded) until it is accepted
    task automatic applyStimulus(input logic [3:0] run, input logic [11:0] veri, input logic [1:0] ch, input logic restart);
        int n;
        modelSymbol(run, veri, ch, restart);
        hd_run_i = run;
        hd_veri_i = veri;
        hd_kanal_i = ch;
        yeniden_i = restart;
        hd_gecerli_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!hd_hazir_o && n < 1000);
        if (!hd_hazir_o) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL accept: hd_hazir_o still 0 after %0d cycles, required 1", n);
        end
        @(posedge clk_i);
        #1;
        hd_gecerli_i = 1'b0;
        yeniden_i = 1'b0;
    endtask

    // One-cycle restart pulse between symbols
    task automatic restartPulse();
        for (int c = 0; c < 3; c++) mPred[c] = '0;
        yeniden_i = 1'b1;
        @(posedge clk_i);
        #1;
        yeniden_i = 1'b0;
    endtask

    // Waits (bounded) until every queued expectation has been transferred
    task automatic waitDrain(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 3000) begin
            @(posedge clk_i);
            n++;
        end
        #1;
        if (expQ.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s drain: %0d outputs outstanding after %0d cycles, required 0", name, expQ.size(), n);
            expQ.delete();
        end
    endtask

    // Monitor: every output transfer is compared with the head of the expectation queue
    always @(negedge clk_i) begin
        expT act;
        expT exp;
        if (rstn_i && ct_gecerli_o && ct_hazir_i) begin
            act = {ct_veri_o, ct_row_o, ct_col_o, ct_kanal_o, ct_blok_son_o};
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL extra output: got 0x%0h, expected no output", act);
            end else begin
                exp = expQ.pop_front();
                checkOutput("coef {veri,row,col,kanal,son}", 32'(act), 32'(exp));
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence
    initial begin
        expT snap;
        buildZigzag();
        modelReset();

        // Reset values while rstn_i is low
        #2 rstn_i = 1'b0;
        #1;
        checkOutput("reset veri", 32'(ct_veri_o), 32'd0);
        checkOutput("reset row/col", 32'({ct_row_o, ct_col_o}), 32'd0);
        checkOutput("reset kanal", 32'(ct_kanal_o), 32'd0);
        checkOutput("reset gecerli", 32'(ct_gecerli_o), 32'd0);
        checkOutput("reset blok_son", 32'(ct_blok_son_o), 32'd0);
        checkOutput("reset hata", 32'(hata_o), 32'd0);
        checkOutput("reset hd_hazir", 32'(hd_hazir_o), 32'd0);
        @(posedge clk_i);
        #1 rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("idle hd_hazir", 32'(hd_hazir_o), 32'd1);

        // ch0 DC 5 then EOB, then prediction across blocks and channels
        applyStimulus(4'd0, 12'd5, 2'd0, 1'b0);
        applyStimulus(4'd0, 12'd0, 2'd0, 1'b0);
        applyStimulus(4'd0, 12'hFFD, 2'd0, 1'b0);
        applyStimulus(4'd0, 12'd0, 2'd0, 1'b0);
        applyStimulus(4'd0, 12'd7, 2'd1, 1'b0);
        applyStimulus(4'd0, 12'd0, 2'd1, 1'b0);
        waitDrain("prediction");
        restartPulse();
        applyStimulus(4'd0, 12'd4, 2'd0, 1'b0);
        applyStimulus(4'd0, 12'd0, 2'd0, 1'b0);

        // Restart coinciding with a DC accept: output equals the difference
        applyStimulus(4'd0, 12'd3, 2'd1, 1'b1);
        applyStimulus(4'd0, 12'd0, 2'd1, 1'b0);

        // Runs of zeros before coefficients
        applyStimulus(4'd0, 12'd1, 2'd2, 1'b0);
        applyStimulus(4'd3, 12'd2, 2'd2, 1'b0);
        applyStimulus(4'd1, 12'd3, 2'd2, 1'b0);
        applyStimulus(4'd0, 12'd0, 2'd2, 1'b0);

        // Three ZRLs then a value landing exactly on k=49
        applyStimulus(4'd0, 12'd0, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(4'd15, 12'd0, 2'd0, 1'b0);
        applyStimulus(4'd0, 12'd9, 2'd0, 1'b0);
        applyStimulus(4'd0, 12'd0, 2'd0, 1'b0);
        waitDrain("zrl");
        checkOutput("hata after zrl", 32'(hata_o), 32'(mHata));

        // Overrun: zeros up to k=63, value dropped, next symbol is a fresh DC
        applyStimulus(4'd0, 12'd0, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(4'd15, 12'd0, 2'd0, 1'b0);
        applyStimulus(4'd15, 12'd4, 2'd0, 1'b0);
        waitDrain("overrun");
        checkOutput("hata after overrun", 32'(hata_o), 32'(mHata));
        applyStimulus(4'd0, 12'd2, 2'd1, 1'b0);
        applyStimulus(4'd0, 12'd0, 2'd1, 1'b0);

        // Predictor wrap past the signed maximum
        applyStimulus(4'd0, 12'd2047, 2'd2, 1'b0);
        applyStimulus(4'd0, 12'd0, 2'd2, 1'b0);
        waitDrain("wrap");

        // Back-pressure during a run=0 stream: outputs frozen, no symbol accepted
        fork
            begin
                applyStimulus(4'd0, 12'd1, 2'd1, 1'b0);
                for (int i = 1; i <= 10; i++) applyStimulus(4'd0, 12'(i * 7), 2'd1, 1'b0);
                applyStimulus(4'd0, 12'd0, 2'd1, 1'b0);
            end
            begin
                repeat (4) @(posedge clk_i);
                #1 ct_hazir_i = 1'b0;
                @(negedge clk_i);
                snap = {ct_veri_o, ct_row_o, ct_col_o, ct_kanal_o, ct_blok_son_o};
                checkOutput("stall gecerli", 32'(ct_gecerli_o), 32'd1);
                checkOutput("stall hd_hazir", 32'(hd_hazir_o), 32'd0);
                repeat (4) begin
                    @(negedge clk_i);
                    checkOutput("stall hold", 32'({ct_veri_o, ct_row_o, ct_col_o, ct_kanal_o, ct_blok_son_o}), 32'(snap));
                    checkOutput("stall hd_hazir", 32'(hd_hazir_o), 32'd0);
                end
                @(posedge clk_i);
                #1 ct_hazir_i = 1'b1;
            end
        join
        waitDrain("stall");

        // Reset in the middle of a block at k=20
        applyStimulus(4'd0, 12'd3, 2'd0, 1'b0);
        for (int i = 1; i <= 19; i++) applyStimulus(4'd0, 12'(i + 1), 2'd0, 1'b0);
        waitDrain("pre-reset");
        rstn_i = 1'b0;
        #1;
        checkOutput("midreset veri", 32'(ct_veri_o), 32'd0);
        checkOutput("midreset row/col", 32'({ct_row_o, ct_col_o}), 32'd0);
        checkOutput("midreset gecerli", 32'(ct_gecerli_o), 32'd0);
        checkOutput("midreset hata", 32'(hata_o), 32'd0);
        checkOutput("midreset hd_hazir", 32'(hd_hazir_o), 32'd0);
        modelReset();
        repeat (2) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        applyStimulus(4'd0, 12'd6, 2'd0, 1'b0);
        applyStimulus(4'd0, 12'd0, 2'd0, 1'b0);

        // EOB arriving when only k=63 is left
        applyStimulus(4'd0, 12'd1, 2'd2, 1'b0);
        for (int i = 1; i <= 62; i++) applyStimulus(4'd0, 12'(i), 2'd2, 1'b0);
        applyStimulus(4'd0, 12'd0, 2'd2, 1'b0);
        waitDrain("eob at 63");
        checkOutput("hata after eob at 63", 32'(hata_o), 32'(mHata));

        // Invalid channel index uses predictor 0 and raises the error flag
        applyStimulus(4'd0, 12'd10, 2'd3, 1'b0);
        applyStimulus(4'd0, 12'd0, 2'd3, 1'b0);
        waitDrain("bad channel");
        checkOutput("hata after bad channel", 32'(hata_o), 32'(mHata));

        // Restart mid-block leaves the block alone but clears the next DC prediction
        applyStimulus(4'd0, 12'd1, 2'd0, 1'b0);
        restartPulse();
        applyStimulus(4'd0, 12'd0, 2'd0, 1'b0);
        applyStimulus(4'd0, 12'd1, 2'd0, 1'b0);
        applyStimulus(4'd0, 12'd0, 2'd0, 1'b0);
        waitDrain("final");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
